// File: rtl/param_datapath.sv
// param_datapath: parameterised register file / shifter / ALU / status datapath with a
// multi-cycle shift-add multiplier. Define DATAPATH_FWD_EN to bypass write-back data into A/B loads.
module param_datapath #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int PCW   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [$clog2(NREG)-1:0] readnum,
    input  logic [$clog2(NREG)-1:0] writenum,
    input  logic                    write,
    input  logic [3:0]              vsel,
    input  logic                    loada,
    input  logic                    loadb,
    input  logic                    loadc,
    input  logic                    loads,
    input  logic                    asel,
    input  logic                    bsel,
    input  logic [1:0]              shift,
    input  logic [2:0]              ALUop,
    input  logic                    start,
    input  logic [WIDTH-1:0]        datapath_in,
    input  logic [WIDTH-1:0]        mdata,
    input  logic [WIDTH-1:0]        sximm,
    input  logic [PCW-1:0]          PC,
    output logic                    busy,
    output logic                    done,
    output logic                    Z_out,
    output logic                    V_out,
    output logic                    N_out,
    output logic [WIDTH-1:0]        datapath_out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [NREG-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]           a_q, b_q, c_q;
    logic [WIDTH-1:0]           wb_data, rd_data, sh_out, ain, bin, alu_res;
    logic                       wb_ok, alu_v, z_q, v_q, n_q, done_q, mul_go;
    logic [2*WIDTH-1:0]         acc, mcand;
    logic [WIDTH-1:0]           mplier;
    logic [CW-1:0]              cnt;

    // Non-one-hot select drops the write rather than merging sources.
    always_comb begin
        wb_ok   = 1'b1;
        wb_data = '0;
        case (vsel)
            4'b0001: wb_data = c_q;
            4'b0010: wb_data = datapath_in;
            4'b0100: wb_data = mdata;
            4'b1000: wb_data = WIDTH'(PC);
            default: wb_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_data = regs[readnum];
`ifdef DATAPATH_FWD_EN
        if (write && wb_ok && (writenum == readnum)) rd_data = wb_data;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (write && wb_ok) begin
            regs[writenum] <= wb_data;
        end
    end

    always_comb begin
        case (shift)
            2'b01:   sh_out = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   sh_out = {1'b0, b_q[WIDTH-1:1]};
            2'b11:   sh_out = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: sh_out = b_q;
        endcase
    end

    assign ain = asel ? '0 : a_q;
    assign bin = bsel ? sximm : sh_out;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (ALUop)
            3'b000: begin
                alu_res = ain + bin;
                alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b001: begin
                alu_res = ain - bin;
                alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b010:  alu_res = ain & bin;
            3'b011:  alu_res = ~bin;
            default: alu_res = '0;
        endcase
    end

    assign busy   = (state != IDLE);
    assign mul_go = (state == IDLE) && start && (ALUop == 3'b100);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mul_go) state_nx = RUN;
            RUN:     if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Unsigned shift-add: multiplicand walks left, multiplier walks right.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (mul_go) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, ain};
            mplier <= bin;
            cnt    <= CW'(WIDTH);
        end else if (state == RUN) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (loada) a_q <= rd_data;
            if (loadb) b_q <= rd_data;
        end
    end

    // The multiplier owns C and status from start until its result lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_q    <= '0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if (state == DONE) begin
                c_q <= acc[WIDTH-1:0];
                z_q <= (acc[WIDTH-1:0] == '0);
                n_q <= acc[WIDTH-1];
                v_q <= |acc[2*WIDTH-1:WIDTH];
            end else if (!busy) begin
                if (loadc) c_q <= alu_res;
                if (loads) begin
                    z_q <= (alu_res == '0);
                    n_q <= alu_res[WIDTH-1];
                    v_q <= alu_v;
                end
            end
        end
    end

    assign done         = done_q;
    assign Z_out        = z_q;
    assign V_out        = v_q;
    assign N_out        = n_q;
    assign datapath_out = c_q;
endmodule

// File: tb/tb_param_datapath.sv
// Randomised self-checking bench for param_datapath (default parameters) against an
// arithmetic reference model, plus directed reset, overflow, shift, multiply and bypass cases.
module tb_param_datapath;
    logic        clk, reset_n;
    logic [2:0]  readnum, writenum, ALUop;
    logic        write, loada, loadb, loadc, loads, asel, bsel, start;
    logic [3:0]  vsel;
    logic [1:0]  shift;
    logic [15:0] datapath_in, mdata, sximm;
    logic [7:0]  PC;
    logic        busy, done, Z_out, V_out, N_out;
    logic [15:0] datapath_out;

    int n_vec = 0, n_err = 0;

    logic [15:0] m_reg [8];
    logic [15:0] m_a, m_b, m_c, m_ma, m_mb;
    bit          m_z, m_v, m_n, m_busy, m_done;
    int          m_left;

    param_datapath dut (
        .clk(clk), .reset_n(reset_n), .readnum(readnum), .writenum(writenum), .write(write),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
        .bsel(bsel), .shift(shift), .ALUop(ALUop), .start(start), .datapath_in(datapath_in),
        .mdata(mdata), .sximm(sximm), .PC(PC), .busy(busy), .done(done), .Z_out(Z_out),
        .V_out(V_out), .N_out(N_out), .datapath_out(datapath_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_a = '0; m_b = '0; m_c = '0; m_ma = '0; m_mb = '0;
        m_z = 0; m_v = 0; m_n = 0; m_busy = 0; m_done = 0; m_left = 0;
    endtask

    // One clock edge of the reference behaviour, evaluated from pre-edge state and inputs.
    task automatic model_step();
        logic [15:0] rd, wb, sh, ain, bin, res;
        logic [31:0] prod;
        bit          wv, v;
        int          s;
        wv = ($countones(vsel) == 1);
        wb = (vsel == 4'b0001) ? m_c : (vsel == 4'b0010) ? datapath_in :
             (vsel == 4'b0100) ? mdata : {8'h00, PC};
        rd = m_reg[readnum];
`ifdef DATAPATH_FWD_EN
        if (write && wv && writenum == readnum) rd = wb;
`endif
        case (shift)
            2'd0: sh = m_b;
            2'd1: sh = 16'((int'(m_b) * 2) % 65536);
            2'd2: sh = m_b / 2;
            default: sh = 16'(sx(m_b) >>> 1);
        endcase
        ain = asel ? 16'h0 : m_a;
        bin = bsel ? sximm : sh;
        v = 0;
        s = 0;
        case (ALUop)
            3'd0: begin s = sx(ain) + sx(bin); res = 16'(s); v = (s > 32767) || (s < -32768); end
            3'd1: begin s = sx(ain) - sx(bin); res = 16'(s); v = (s > 32767) || (s < -32768); end
            3'd2: res = ain & bin;
            3'd3: res = ~bin;
            default: res = 16'h0;
        endcase
        if (m_busy) begin
            m_left--;
            m_done = 0;
            if (m_left == 0) begin
                prod = 32'(m_ma) * 32'(m_mb);
                m_c = prod[15:0];
                m_z = (prod[15:0] == 0); m_n = prod[15]; m_v = (prod[31:16] != 0);
                m_busy = 0; m_done = 1;
            end
        end else begin
            m_done = 0;
            if (loadc) m_c = res;
            if (loads) begin m_z = (res == 0); m_n = res[15]; m_v = v; end
            if (start && ALUop == 3'd4) begin
                m_ma = ain; m_mb = bin; m_busy = 1; m_left = 17;
            end
        end
        if (loada) m_a = rd;
        if (loadb) m_b = rd;
        if (write && wv) m_reg[writenum] = wb;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("c", datapath_out, m_c);
        chk("z", Z_out, m_z);
        chk("v", V_out, m_v);
        chk("n", N_out, m_n);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    endtask

    task automatic set_idle();
        write = 0; vsel = 4'b0000; loada = 0; loadb = 0; loadc = 0; loads = 0;
        asel = 0; bsel = 0; shift = 2'd0; ALUop = 3'd0; start = 0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] d);
        set_idle(); write = 1; writenum = r; vsel = 4'b0010; datapath_in = d;
        cyc(); set_idle();
    endtask

    task automatic rd_reg(input logic [2:0] r);
        set_idle(); readnum = r; loadb = 1; cyc();
        set_idle(); asel = 1; loadc = 1; cyc(); set_idle();
    endtask

    task automatic load_ab(input logic [2:0] ra, input logic [2:0] rb);
        set_idle(); readnum = ra; loada = 1; cyc();
        set_idle(); readnum = rb; loadb = 1; cyc(); set_idle();
    endtask

    task automatic do_reset();
        #2 reset_n = 0;
        #1;
        model_zero();
        chk("rst_c", datapath_out, 16'h0);
        chk("rst_flags", {Z_out, V_out, N_out}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk) reset_n = 1;
    endtask

    // Start counts as edge 1; optional busy-window interference.
    task automatic mul_run(input logic [15:0] a, input logic [15:0] b, input bit il);
        int nb = 0, nd = 0, dk = 0;
        wr(0, a); wr(1, b); load_ab(0, 1);
        ALUop = 3'd4; start = 1;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            if (busy) nb++;
            if (done) begin nd++; if (dk == 0) dk = k; end
            set_idle();
            if (il && k == 4) begin loadc = 1; loads = 1; start = 1; ALUop = 3'd4; end
            if (il && k == 6) begin write = 1; writenum = 3'd5; vsel = 4'b0010; datapath_in = 16'h5A5A; end
        end
        chk("mul_busy_cycles", nb, 17);
        chk("mul_done_count", nd, 1);
        chk("mul_done_cycle", dk, 18);
    endtask

    initial begin
        set_idle();
        readnum = 0; writenum = 0; datapath_in = 0; mdata = 0; sximm = 0; PC = 0;
        model_zero();
        reset_n = 0;
        #3;
        chk("por_c", datapath_out, 16'h0);
        chk("por_busy", busy, 1'b0);
        @(negedge clk) reset_n = 1;

        // Reset mid-multiply with live register contents.
        wr(3, 16'h1234); wr(0, 16'h0005); wr(1, 16'h0007); load_ab(0, 1);
        ALUop = 3'd4; start = 1; cyc(); set_idle();
        for (int k = 0; k < 4; k++) cyc();
        do_reset();
        for (int k = 0; k < 20; k++) cyc();
        for (int r = 0; r < 8; r++) begin
            rd_reg(3'(r));
            chk("rst_reg", datapath_out, 16'h0);
        end

        // ADD overflow, SUB to zero.
        wr(0, 16'h7FFF); wr(1, 16'h0001); load_ab(0, 1);
        loadc = 1; loads = 1; cyc();
        chk("add_c", datapath_out, 16'h8000);
        chk("add_nvz", {N_out, V_out, Z_out}, 3'b110);
        set_idle(); readnum = 1; loada = 1; cyc();
        set_idle(); ALUop = 3'd1; loadc = 1; loads = 1; cyc();
        chk("sub_c", datapath_out, 16'h0);
        chk("sub_z", Z_out, 1'b1);

        // Arithmetic shift and immediate path.
        wr(4, 16'h8001);
        set_idle(); readnum = 4; loadb = 1; cyc();
        set_idle(); shift = 2'b11; asel = 1; loadc = 1; cyc();
        chk("asr_c", datapath_out, 16'hC000);
        set_idle(); bsel = 1; sximm = 16'hFFFB; asel = 1; loadc = 1; cyc();
        chk("imm_c", datapath_out, 16'hFFFB);
        set_idle();

        // Multiply, then multiply with high-word overflow and busy interference.
        mul_run(16'h0012, 16'h0034, 0);
        chk("mul1_c", datapath_out, 16'h03A8);
        chk("mul1_v", V_out, 1'b0);
        wr(5, 16'h0000);
        mul_run(16'h0100, 16'h0100, 1);
        chk("mul2_c", datapath_out, 16'h0000);
        chk("mul2_zv", {Z_out, V_out}, 2'b11);
        rd_reg(5);
        chk("busy_write", datapath_out, 16'h5A5A);

        // Same-edge write and read of R2, then a suppressed write.
        wr(2, 16'h1111);
        set_idle(); write = 1; writenum = 2; vsel = 4'b0010; datapath_in = 16'hABCD;
        readnum = 2; loada = 1; cyc();
        set_idle(); bsel = 1; sximm = 16'h0; loadc = 1; cyc();
`ifdef DATAPATH_FWD_EN
        chk("fwd_a", datapath_out, 16'hABCD);
`else
        chk("fwd_a", datapath_out, 16'h1111);
`endif
        set_idle(); write = 1; writenum = 2; vsel = 4'b0011; datapath_in = 16'h5555; cyc();
        rd_reg(2);
        chk("vsel_bad", datapath_out, 16'hABCD);

        // Random traffic, including multiplies overlapped with loads and writes.
        for (int i = 0; i < 800; i++) begin
            write = 1'($urandom); writenum = 3'($urandom); readnum = 3'($urandom);
            vsel = ($urandom_range(4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3));
            datapath_in = 16'($urandom); mdata = 16'($urandom); sximm = 16'($urandom);
            PC = 8'($urandom);
            loada = 1'($urandom); loadb = 1'($urandom); loadc = 1'($urandom); loads = 1'($urandom);
            asel = ($urandom_range(3) == 0); bsel = 1'($urandom); shift = 2'($urandom);
            ALUop = 3'($urandom); start = ($urandom_range(5) == 0);
            if (ALUop == 3'd4) begin loadc = 0; loads = 0; end
            cyc();
        end
        set_idle();
        for (int k = 0; k < 20; k++) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
Parametrised successor to the 16-bit lab datapath: register file, A/B/C operand/result registers, shifter, ALU and status register. Width and register count are generic. Adds a multi-cycle shift-add multiplier with a start/busy/done handshake, and reset of every storage element. Sits under the CPU controller FSM, which drives all load/select strobes.

Parameters:
WIDTH, 16, datapath word width (>= 4)
NREG, 8, register-file entries (power of two, >= 2)
PCW, 8, PC width, zero-extended into the write-back mux (PCW <= WIDTH)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
readnum  in  $clog2(NREG)  register-file read index (combinational read)
writenum  in  $clog2(NREG)  register-file write index
write  in  1  register-file write enable
vsel  in  4  one-hot write-back select: 0001 C, 0010 datapath_in, 0100 mdata, 1000 {0,PC}
loada, loadb, loadc, loads  in  1 each  A, B, C, status load enables
asel  in  1  1: ALU A operand = 0, 0: A register
bsel  in  1  1: ALU B operand = sximm, 0: shifter output
shift  in  2  00 pass, 01 shl1 (fill 0), 10 lsr1 (fill 0), 11 asr1 (copy MSB)
ALUop  in  3  000 ADD, 001 SUB, 010 AND, 011 NOT B, 100 MUL, 101-111 reserved
start  in  1  start multiply (honoured only when ALUop=100 and idle)
datapath_in, mdata, sximm  in  WIDTH each  write-back / immediate sources
PC  in  PCW  program counter
busy  out  1  multiplier running
done  out  1  one-cycle pulse when the product is written to C
Z_out, V_out, N_out  out  1 each  registered status flags
datapath_out  out  WIDTH  C register

Behaviour:
- Reset (async, reset_n=0): all NREG registers, A, B, C, status = 0; busy=0, done=0; FSM to IDLE.
- Register file: synchronous write on the clk edge when write=1. Data comes from the vsel mux. A vsel that is not one-hot suppresses the write (no X propagation). Read is combinational.
- A, B, C and status: each loads on the clk edge when its enable is 1, otherwise holds its value.
- Single-cycle ops (ADD/SUB/AND/NOT B): result is combinational. It reaches C on the edge with loadc=1 and status on the edge with loads=1.
- Reserved ALUop values: result = 0, flags Z=1, V=0, N=0.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB; 0 for AND/NOT.
- Arithmetic is modulo 2^WIDTH.
- Multiplier FSM, IDLE -> RUN -> DONE -> IDLE:
  - IDLE: start=1 with ALUop=100 latches Ain and Bin (after asel/bsel/shift), clears a 2*WIDTH accumulator, loads a counter with WIDTH, and sets busy on the next cycle.
  - RUN: one shift-add step per cycle, unsigned. After WIDTH steps, go to DONE.
  - DONE (one cycle): C <= product[WIDTH-1:0]. Status is always loaded, with Z and N from the low word and V = |product[2W-1:W]. done=1, busy drops, return to IDLE.
  - Latency: start edge to done pulse = WIDTH+2 cycles.
- While busy (RUN or DONE):
  - loadc and loads are ignored.
  - start is ignored.
  - loada, loadb and write remain honoured; the latched operands are unaffected.
- start with ALUop != 100 is ignored; the FSM stays in IDLE.
- Reset asserted mid-multiply aborts the operation. C is cleared and no done pulse is produced.

Optional Feature:
DATAPATH_FWD_EN
- Defined: write-through bypass. When write=1, vsel is valid and writenum==readnum in the same cycle, loada/loadb capture the write-back data instead of the stale register value.
- Undefined: A/B capture the pre-write register value, i.e. same-cycle read-before-write.

Test Plan:
1. Reset: reset_n=0 mid-run with R3=0x1234 -> all regs, C, flags, busy and done read 0 immediately, without waiting for a clk edge.
2. ADD overflow: R0=0x7FFF, R1=0x0001, ADD, loadc, loads -> C=0x8000, N=1, V=1, Z=0. SUB of R1 from itself -> C=0, Z=1.
3. Shift/immediate: B=0x8001 with shift=11 -> ALU B=0xC000. bsel=1, sximm=0xFFFB, asel=1, ADD -> C=0xFFFB.
4. MUL: A=0x0012, B=0x0034, start -> busy for WIDTH+1 cycles, done pulse at cycle 18, C=0x03A8, V=0. A=0x0100, B=0x0100 -> C=0x0000, Z=1, V=1.
5. Busy interlock: pulse loadc and start during RUN -> C unchanged until done, and only one done pulse. A write to R5 during RUN lands.
6. Bypass: write R2 with datapath_in=0xABCD, readnum=2, loada=1 on the same edge -> A=0xABCD when DATAPATH_FWD_EN is defined, else the old R2 value. A non-one-hot vsel=0011 -> R2 unchanged.
